pc_ras_unit: RTL and testbench
==============================

Name: pc_ras_unit

Overview:
Parametrised next-generation program counter for the fetch stage. It supports sequential advance, PC-relative branch and jump, and call/return through an internal return-address stack (RAS). It drives the fetch address every cycle and reports RAS status to the hazard/debug logic.

Parameters:
PC_W, 16, program counter width in bits
INSTR_BYTES, 2, instruction size in bytes; sequential increment value
BR_IMM_W, 6, branch immediate width (two's complement)
JMP_IMM_W, 12, jump/call immediate width (two's complement)
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk_pi  in  1  clock, rising edge
reset_pi  in  1  asynchronous active-high reset
clk_en_pi  in  1  global clock enable; 0 = freeze all state
stall_pi  in  1  pipeline stall; 1 = hold PC and RAS
branch_taken_pi  in  1  taken conditional branch
branch_immediate_pi  in  BR_IMM_W  signed branch offset
jump_taken_pi  in  1  unconditional jump
jump_immediate_pi  in  JMP_IMM_W  signed jump/call offset
call_pi  in  1  call: push return address, then jump by jump_immediate_pi
ret_pi  in  1  return: pop RAS top into PC
pc_po  out  PC_W  current PC
ras_empty_po  out  1  RAS holds 0 entries
ras_full_po  out  1  RAS holds RAS_DEPTH entries
ras_overflow_po  out  1  sticky: a call was made while the RAS was full
ras_underflow_po  out  1  sticky: a return was made while the RAS was empty

Behaviour:
- Reset, asynchronous, takes effect immediately: pc_po=RESET_PC; RAS count=0; ras_empty_po=1; ras_full_po=0; both sticky flags=0. Reset overrides everything, including mid-cycle and while a call/return is in progress.
- Advance condition: adv = clk_en_pi & ~stall_pi. If adv=0, PC, RAS contents, count and flags hold.
- When adv=1, the next PC is selected by fixed priority ret > call > branch > jump > sequential. Lower-priority requests in the same cycle are ignored, with no side effects.
- Let seq = PC + INSTR_BYTES.
  - sequential: PC <= seq
  - branch: PC <= seq + sext(branch_immediate_pi)
  - jump: PC <= seq + sext(jump_immediate_pi)
  - call: PC <= seq + sext(jump_immediate_pi); push seq
  - ret, RAS non-empty: PC <= RAS top; pop
  - ret, RAS empty: PC <= seq; ras_underflow_po <= 1; count stays 0
- Arithmetic: immediates are sign-extended to PC_W. All sums are modulo 2^PC_W, so wrap-around is silent (e.g. 0xFFFE+2 = 0x0000).
- RAS is a circular LIFO with a top pointer and a count (0..RAS_DEPTH).
  - Push when full: overwrite the oldest entry, pointer advances, count stays at RAS_DEPTH, ras_overflow_po <= 1.
  - Subsequent pops return the newest RAS_DEPTH addresses in order.
- Sticky flags clear only on reset.
- Latency: the PC update is visible on pc_po the cycle after the qualifying edge. Status outputs are registered or derived from registered count, and reflect the same edge.
- Outputs are glitch-free registered values; no combinational path from inputs to outputs.

Decomposition:
- Shared package pc_pkg:
  - enum next_pc_sel_e {SEL_SEQ, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET}
  - function sext_to_pc (sign-extension helper)
  - default constants (DEF_PC_W=16, DEF_INSTR_BYTES=2)
- Sub-module ras_stack:
  - params: DATA_W, DEPTH
  - ports: clk_pi, reset_pi, push, pop, push_data, top_data, empty, full, overflow, underflow
  - owns the circular pointer, count and sticky flags
- pc_ras_unit contains the priority select, the adders and the PC register.

Test Plan:
1. Reset asserted asynchronously mid-cycle with PC=0x0040 and RAS count=2 -> pc_po=0x0000 immediately; empty=1, full=0, flags=0.
2. adv=1 for 3 idle cycles from 0x0000 -> pc_po 0x0002, 0x0004, 0x0006. Then stall_pi=1 for 2 cycles -> holds 0x0006. clk_en_pi=0 also holds.
3. PC=0x0010, branch_immediate=6'b111100 (-4) -> 0x000E. Branch and jump both asserted with jump_imm=0x010 -> branch wins, giving 0x000E.
4. PC=0x0020, call_pi with jump_imm=0x100 -> PC=0x0122, RAS top=0x0022. Then ret_pi -> PC=0x0022, empty=1. ret and call in the same cycle -> ret wins and no push occurs.
5. With RAS_DEPTH=4, 5 nested calls pushing A1..A5 -> full=1, overflow=1. 4 returns -> PCs A5, A4, A3, A2, then empty=1. A 5th return -> PC=seq, underflow=1.
6. Wrap-around: PC=0xFFFE sequential -> 0x0000. PC=0x0000, jump_imm=0xFFE (-2) -> 0x0000.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage next-PC logic.
package pc_pkg;
  localparam int DEF_PC_W        = 16;
  localparam int DEF_INSTR_BYTES = 2;

  typedef enum logic [2:0] {SEL_SEQ, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET} next_pc_sel_e;

  // Sign-extends the low w bits of imm to 64 bits; callers truncate to PC width.
  function automatic logic [63:0] sext_to_pc(input logic [63:0] imm, input int unsigned w);
    logic signed [63:0] t;
    t = $signed(imm << (64 - w));
    return $unsigned(t >>> (64 - w));
  endfunction
endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk_pi,
  input  logic              reset_pi,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top_data,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PTR_W-1:0]             ptr;
  logic [CNT_W-1:0]             cnt;

  // ptr always indexes the newest entry; wrap relies on DEPTH being a power of two.
  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      mem       <= '0;
      ptr       <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (pop) begin
      if (cnt != '0) begin
        ptr <= ptr - PTR_W'(1);
        cnt <= cnt - CNT_W'(1);
      end else begin
        underflow <= 1'b1;
      end
    end else if (push) begin
      ptr                   <= ptr + PTR_W'(1);
      mem[ptr + PTR_W'(1)]  <= push_data;
      if (cnt == CNT_W'(DEPTH)) overflow <= 1'b1;
      else                      cnt      <= cnt + CNT_W'(1);
    end
  end

  assign top_data = mem[ptr];
  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_W'(DEPTH));
endmodule

// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter: sequential, branch, jump, call and return via RAS.
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int PC_W        = DEF_PC_W,
  parameter int INSTR_BYTES = DEF_INSTR_BYTES,
  parameter int BR_IMM_W    = 6,
  parameter int JMP_IMM_W   = 12,
  parameter int RAS_DEPTH   = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk_pi,
  input  logic                 reset_pi,
  input  logic                 clk_en_pi,
  input  logic                 stall_pi,
  input  logic                 branch_taken_pi,
  input  logic [BR_IMM_W-1:0]  branch_immediate_pi,
  input  logic                 jump_taken_pi,
  input  logic [JMP_IMM_W-1:0] jump_immediate_pi,
  input  logic                 call_pi,
  input  logic                 ret_pi,
  output logic [PC_W-1:0]      pc_po,
  output logic                 ras_empty_po,
  output logic                 ras_full_po,
  output logic                 ras_overflow_po,
  output logic                 ras_underflow_po
);
  logic            adv;
  next_pc_sel_e    sel;
  logic [PC_W-1:0] seq, br_off, jmp_off, ras_top, pc_nxt;
  logic            push, pop;

  assign adv     = clk_en_pi & ~stall_pi;
  assign seq     = pc_po + PC_W'(INSTR_BYTES);
  assign br_off  = PC_W'(sext_to_pc(64'(branch_immediate_pi), BR_IMM_W));
  assign jmp_off = PC_W'(sext_to_pc(64'(jump_immediate_pi), JMP_IMM_W));

  always_comb begin
    sel = SEL_SEQ;
    if      (ret_pi)          sel = SEL_RET;
    else if (call_pi)         sel = SEL_CALL;
    else if (branch_taken_pi) sel = SEL_BR;
    else if (jump_taken_pi)   sel = SEL_JMP;
  end

  // A return on an empty stack falls through to seq; the stack flags underflow.
  always_comb begin
    pc_nxt = seq;
    case (sel)
      SEL_BR:   pc_nxt = seq + br_off;
      SEL_JMP,
      SEL_CALL: pc_nxt = seq + jmp_off;
      SEL_RET:  pc_nxt = ras_empty_po ? seq : ras_top;
      default:  pc_nxt = seq;
    endcase
  end

  assign push = adv & (sel == SEL_CALL);
  assign pop  = adv & (sel == SEL_RET);

  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) pc_po <= RESET_PC;
    else if (adv) pc_po <= pc_nxt;
  end

  ras_stack #(.DATA_W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk_pi    (clk_pi),
    .reset_pi  (reset_pi),
    .push      (push),
    .pop       (pop),
    .push_data (seq),
    .top_data  (ras_top),
    .empty     (ras_empty_po),
    .full      (ras_full_po),
    .overflow  (ras_overflow_po),
    .underflow (ras_underflow_po)
  );
endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit: vector table plus RAS overflow, wrap and reset sequences.
module tb_pc_ras_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        en, stall, br, jmp, call, ret;
  logic [5:0]  bimm;
  logic [11:0] jimm;
  logic [15:0] pc;
  logic        empty, full, ovf, unf;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  pc_ras_unit dut (
    .clk_pi(clk), .reset_pi(rst), .clk_en_pi(en), .stall_pi(stall),
    .branch_taken_pi(br), .branch_immediate_pi(bimm),
    .jump_taken_pi(jmp), .jump_immediate_pi(jimm),
    .call_pi(call), .ret_pi(ret), .pc_po(pc),
    .ras_empty_po(empty), .ras_full_po(full),
    .ras_overflow_po(ovf), .ras_underflow_po(unf)
  );

  typedef struct {
    logic        stall, en, br;
    logic [5:0]  bimm;
    logic        jmp;
    logic [11:0] jimm;
    logic        call, ret;
    logic [15:0] pc;
    logic        empty, full;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic s, input logic e, input logic b, input logic [5:0] bi,
                        input logic j, input logic [11:0] ji, input logic c, input logic r);
    stall = s; en = e; br = b; bimm = bi; jmp = j; jimm = ji; call = c; ret = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            stall en br bimm    jmp jimm     call ret  pc        empty full
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 12'h000, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 12'h000, 1'b0, 1'b0, 16'h0004, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 12'h000, 1'b0, 1'b0, 16'h0006, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 12'h000, 1'b0, 1'b0, 16'h0006, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 12'h000, 1'b0, 1'b0, 16'h0006, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 12'h000, 1'b0, 1'b0, 16'h0006, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 12'h040, 1'b1, 1'b0, 16'h0006, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 6'h00, 1'b1, 12'h008, 1'b0, 1'b0, 16'h0010, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 6'h3C, 1'b0, 12'h000, 1'b0, 1'b0, 16'h000E, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 6'h00, 1'b1, 12'h000, 1'b0, 1'b0, 16'h0010, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 6'h3C, 1'b1, 12'h010, 1'b0, 1'b0, 16'h000E, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 6'h00, 1'b1, 12'h010, 1'b0, 1'b0, 16'h0020, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 12'h100, 1'b1, 1'b0, 16'h0122, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 12'h000, 1'b0, 1'b1, 16'h0022, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 12'h000, 1'b1, 1'b0, 16'h0024, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 12'h100, 1'b1, 1'b1, 16'h0024, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 12'h100, 1'b1, 1'b0, 16'h0024, 1'b1, 1'b0};

    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset_pc", pc, 16'h0000);
    chk("reset_empty", 16'(empty), 16'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("first_seq", pc, 16'h0002);
    // restart from a clean reset so the table begins at PC 0
    rst = 1'b1; #1; rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].stall, tbl[i].en, tbl[i].br, tbl[i].bimm,
             tbl[i].jmp, tbl[i].jimm, tbl[i].call, tbl[i].ret);
      step();
      chk($sformatf("vec%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("vec%0d_empty", i), 16'(empty), 16'(tbl[i].empty));
      chk($sformatf("vec%0d_full", i), 16'(full), 16'(tbl[i].full));
    end
    chk("tbl_ovf", 16'(ovf), 16'd0);
    chk("tbl_unf", 16'(unf), 16'd0);

    begin
      logic [15:0] call_pc[5];
      logic [15:0] ret_pc[4];
      call_pc = '{16'h0036, 16'h0048, 16'h005A, 16'h006C, 16'h007E};
      ret_pc  = '{16'h006E, 16'h005C, 16'h004A, 16'h0038};
      for (int i = 0; i < 5; i++) begin
        set_in(0, 1, 0, 0, 0, 12'h010, 1, 0);
        step();
        chk($sformatf("call%0d_pc", i), pc, call_pc[i]);
        chk($sformatf("call%0d_full", i), 16'(full), (i >= 3) ? 16'd1 : 16'd0);
        chk($sformatf("call%0d_ovf", i), 16'(ovf), (i == 4) ? 16'd1 : 16'd0);
      end
      for (int i = 0; i < 4; i++) begin
        set_in(0, 1, 0, 0, 0, 0, 0, 1);
        step();
        chk($sformatf("ret%0d_pc", i), pc, ret_pc[i]);
        chk($sformatf("ret%0d_empty", i), 16'(empty), (i == 3) ? 16'd1 : 16'd0);
      end
      set_in(0, 1, 0, 0, 0, 0, 0, 1);
      step();
      chk("uf_pc", pc, 16'h003A);
      chk("uf_flag", 16'(unf), 16'd1);
      chk("uf_empty", 16'(empty), 16'd1);
      chk("ovf_sticky", 16'(ovf), 16'd1);
    end

    set_in(0, 1, 0, 0, 1, 12'hFC2, 0, 0); step();
    chk("to_fffe", pc, 16'hFFFE);
    set_in(0, 1, 0, 0, 0, 0, 0, 0); step();
    chk("wrap_seq", pc, 16'h0000);
    set_in(0, 1, 0, 0, 1, 12'hFFE, 0, 0); step();
    chk("jmp_neg2", pc, 16'h0000);

    set_in(0, 1, 0, 0, 0, 12'h00E, 1, 0); step();
    chk("pre_call1", pc, 16'h0010);
    set_in(0, 1, 0, 0, 0, 12'h02E, 1, 0); step();
    chk("pre_call2", pc, 16'h0040);
    chk("pre_rst_empty", 16'(empty), 16'd0);
    set_in(0, 1, 0, 0, 0, 12'h100, 1, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", pc, 16'h0000);
    chk("arst_empty", 16'(empty), 16'd1);
    chk("arst_full", 16'(full), 16'd0);
    chk("arst_ovf", 16'(ovf), 16'd0);
    chk("arst_unf", 16'(unf), 16'd0);
    step();
    chk("rst_hold_pc", pc, 16'h0000);
    #2 rst = 1'b0;
    set_in(0, 1, 0, 0, 0, 0, 0, 1); step();
    chk("post_rst_ret_pc", pc, 16'h0002);
    chk("post_rst_unf", 16'(unf), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
